// File: rtl/ext_bus_initiator_if.sv
// Signal bundle for ext_bus_initiator: command port, response port and the external register bus.
// The master modport is the initiator's view; slave is the client/responder view.
interface ext_bus_initiator_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 16
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_rw;
    logic [ADDR_WIDTH-1:0] cmd_address;
    logic [BE_WIDTH-1:0]   cmd_byte_enable;
    logic [DATA_WIDTH-1:0] cmd_write_data;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_error;

    logic [ADDR_WIDTH-1:0] address;
    logic                  bus_enable;
    logic [BE_WIDTH-1:0]   byte_enable;
    logic                  rw;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  acknowledge;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        input  cmd_valid, cmd_rw, cmd_address, cmd_byte_enable, cmd_write_data,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_error,
        input  rsp_ready,
        output address, bus_enable, byte_enable, rw, write_data,
        input  acknowledge, read_data
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_address, cmd_byte_enable, cmd_write_data,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_error,
        output rsp_ready,
        input  address, bus_enable, byte_enable, rw, write_data,
        output acknowledge, read_data
    );
endinterface

// File: rtl/ext_bus_initiator.sv
// Single-command initiator for the external register bus: one bus transaction per command, one response each.
// Optional bus timeout enabled by defining EXT_BUS_TIMEOUT_EN.
module ext_bus_initiator #(
    parameter int ADDR_WIDTH     = 19,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    ext_bus_initiator_if.master bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic                  bus_enable_q, bus_enable_d;
    logic [BE_WIDTH-1:0]   byte_enable_q, byte_enable_d;
    logic                  rw_q, rw_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_error_q, rsp_error_d;

`ifdef EXT_BUS_TIMEOUT_EN
    localparam int                   CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic                 timeout_hit;
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        bus_enable_d  = bus_enable_q;
        byte_enable_d = byte_enable_q;
        rw_d          = rw_q;
        write_data_d  = write_data_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_error_d   = rsp_error_q;
`ifdef EXT_BUS_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_hit   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (|bus.cmd_byte_enable) begin
                        address_d     = bus.cmd_address;
                        byte_enable_d = bus.cmd_byte_enable;
                        rw_d          = bus.cmd_rw;
                        write_data_d  = bus.cmd_write_data;
                        bus_enable_d  = 1'b1;
                        state_d       = BUS;
`ifdef EXT_BUS_TIMEOUT_EN
                        wait_cnt_d    = '0;
`endif
                    end else begin
                        // No lanes selected: reject without touching the bus.
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_error_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            BUS: begin
`ifdef EXT_BUS_TIMEOUT_EN
                timeout_hit = (wait_cnt_q + CNT_ONE) == CNT_LIMIT;
`endif
                // Acknowledge takes priority over a timeout landing on the same edge.
                if (bus.acknowledge) begin
                    bus_enable_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = rw_q ? bus.read_data : '0;
                    rsp_error_d  = 1'b0;
                    state_d      = RESP;
                end
`ifdef EXT_BUS_TIMEOUT_EN
                else if (timeout_hit) begin
                    bus_enable_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = '0;
                    rsp_error_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
`endif
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            address_q     <= '0;
            bus_enable_q  <= 1'b0;
            byte_enable_q <= '0;
            rw_q          <= 1'b1;
            write_data_q  <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
`ifdef EXT_BUS_TIMEOUT_EN
            wait_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            address_q     <= address_d;
            bus_enable_q  <= bus_enable_d;
            byte_enable_q <= byte_enable_d;
            rw_q          <= rw_d;
            write_data_q  <= write_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_error_q   <= rsp_error_d;
`ifdef EXT_BUS_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
`endif
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.address     = address_q;
    assign bus.bus_enable  = bus_enable_q;
    assign bus.byte_enable = byte_enable_q;
    assign bus.rw          = rw_q;
    assign bus.write_data  = write_data_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_error   = rsp_error_q;
endmodule

// File: tb/tb_ext_bus_initiator.sv
// Bench for ext_bus_initiator: a transaction-timeline model sets the expected outputs for every cycle
// and one negedge process compares them; directed cases pin the model with literal values.
module tb_ext_bus_initiator;
    localparam int AW  = 19;
    localparam int DW  = 16;
    localparam int BW  = DW / 8;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ext_bus_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

    ext_bus_initiator #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .bus        (bif.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected outputs for the current cycle
    logic          chk_en = 1'b0, chk_bus = 1'b0, chk_rsp = 1'b0;
    logic          e_cmd_ready, e_bus_enable, e_rsp_valid, e_rw, e_rsp_error;
    logic [AW-1:0] e_address;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_wd, e_rsp_data;
    logic          perm_rdy = 1'b0;

    // Observations gathered by the compare process
    int            run_len = 0, gap_len = 0, last_run = 0, n_runs = 0, n_rsp = 0;
    logic          seen_run = 1'b0;
    logic [DW-1:0] last_rsp_data = '0;
    logic          last_rsp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_ready", 32'(bif.cmd_ready), 32'(e_cmd_ready));
            check("bus_enable", 32'(bif.bus_enable), 32'(e_bus_enable));
            check("rsp_valid", 32'(bif.rsp_valid), 32'(e_rsp_valid));
            if (chk_bus) begin
                check("address", 32'(bif.address), 32'(e_address));
                check("byte_enable", 32'(bif.byte_enable), 32'(e_be));
                check("rw", 32'(bif.rw), 32'(e_rw));
                check("write_data", 32'(bif.write_data), 32'(e_wd));
            end
            if (chk_rsp) begin
                check("rsp_data", 32'(bif.rsp_data), 32'(e_rsp_data));
                check("rsp_error", 32'(bif.rsp_error), 32'(e_rsp_error));
            end
        end
        if (rst) begin
            seen_run = 1'b0;
            run_len  = 0;
            gap_len  = 0;
        end else if (bif.bus_enable) begin
            if (run_len == 0 && seen_run) begin
                n_cmp++;
                if (gap_len < 2) begin
                    n_bad++;
                    $display("FAIL bus_gap: got %0d low cycles expected >= 2 at %0t", gap_len, $time);
                end
            end
            run_len++;
            gap_len = 0;
        end else begin
            if (run_len != 0) begin
                last_run = run_len;
                n_runs++;
                seen_run = 1'b1;
            end
            run_len = 0;
            gap_len++;
        end
        if (bif.rsp_valid && bif.rsp_ready) begin
            last_rsp_data = bif.rsp_data;
            last_rsp_err  = bif.rsp_error;
            n_rsp++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        e_cmd_ready  = 1'b1;
        e_bus_enable = 1'b0;
        e_rsp_valid  = 1'b0;
        chk_bus      = 1'b0;
        chk_rsp      = 1'b0;
    endtask

    task automatic set_reset_exp();
        chk_en       = 1'b1;
        e_cmd_ready  = 1'b1;
        e_bus_enable = 1'b0;
        e_rsp_valid  = 1'b0;
        e_address    = '0;
        e_be         = '0;
        e_rw         = 1'b1;
        e_wd         = '0;
        e_rsp_data   = '0;
        e_rsp_error  = 1'b0;
        chk_bus      = 1'b1;
        chk_rsp      = 1'b1;
    endtask

    task automatic drive_idle_inputs();
        bif.cmd_valid       = 1'b0;
        bif.cmd_rw          = 1'($urandom);
        bif.cmd_address     = AW'($urandom);
        bif.cmd_byte_enable = BW'($urandom);
        bif.cmd_write_data  = DW'($urandom);
        bif.read_data       = DW'($urandom);
    endtask

    task automatic idle_cycles(input int n, input bit stray_ack);
        for (int i = 0; i < n; i++) begin
            set_idle();
            drive_idle_inputs();
            bif.acknowledge = stray_ack ? 1'b1 : 1'($urandom);
            bif.rsp_ready   = perm_rdy ? 1'b1 : 1'($urandom);
            tick();
        end
        set_idle();
    endtask

    // One command from an idle cycle to the idle cycle after its response handshake.
    // d: bus cycle carrying acknowledge; s: stall cycles before rsp_ready; rst_at: bus cycle to reset in (0 = none).
    task automatic run_txn(input logic rw_i, input logic [AW-1:0] a, input logic [BW-1:0] be,
                           input logic [DW-1:0] wd, input int d, input int s,
                           input logic [DW-1:0] rdat, input int rst_at);
        int   bus_len;
        logic tmo;
        logic [DW-1:0] rd_exp;
        bif.cmd_valid       = 1'b1;
        bif.cmd_rw          = rw_i;
        bif.cmd_address     = a;
        bif.cmd_byte_enable = be;
        bif.cmd_write_data  = wd;
        bif.acknowledge     = 1'($urandom);
        bif.rsp_ready       = perm_rdy ? 1'b1 : 1'($urandom);
        tick();
        drive_idle_inputs();
        tmo    = 1'b0;
        rd_exp = '0;
        if (be != '0) begin
            bus_len = d;
`ifdef EXT_BUS_TIMEOUT_EN
            if (d > TMO) begin
                bus_len = TMO;
                tmo     = 1'b1;
            end
`endif
            for (int k = 1; k <= bus_len; k++) begin
                e_cmd_ready  = 1'b0;
                e_bus_enable = 1'b1;
                e_rsp_valid  = 1'b0;
                e_address    = a;
                e_be         = be;
                e_rw         = rw_i;
                e_wd         = wd;
                chk_bus      = 1'b1;
                chk_rsp      = 1'b0;
                bif.acknowledge = (k == d);
                bif.read_data   = (k == d) ? rdat : DW'($urandom);
                bif.rsp_ready   = perm_rdy ? 1'b1 : 1'($urandom);
                if (k == rst_at) rst = 1'b1;
                tick();
                if (k == rst_at) begin
                    set_reset_exp();
                    rst             = 1'b0;
                    bif.acknowledge = 1'b0;
                    tick();
                    set_idle();
                    return;
                end
            end
            if (rw_i && !tmo) rd_exp = rdat;
        end else begin
            tmo = 1'b1;
        end
        for (int r = 1; r <= s + 1; r++) begin
            e_cmd_ready  = 1'b0;
            e_bus_enable = 1'b0;
            e_rsp_valid  = 1'b1;
            e_rsp_data   = rd_exp;
            e_rsp_error  = tmo;
            chk_bus      = 1'b0;
            chk_rsp      = 1'b1;
            bif.acknowledge = 1'($urandom);
            bif.read_data   = DW'($urandom);
            bif.rsp_ready   = perm_rdy ? 1'b1 : (r == s + 1);
            tick();
        end
        set_idle();
    endtask

    initial begin
        int runs_before, rsp_before;
        bif.cmd_valid       = 1'b0;
        bif.cmd_rw          = 1'b0;
        bif.cmd_address     = '0;
        bif.cmd_byte_enable = '0;
        bif.cmd_write_data  = '0;
        bif.rsp_ready       = 1'b0;
        bif.acknowledge     = 1'b0;
        bif.read_data       = '0;

        rst = 1'b1;
        tick();
        set_reset_exp();
        tick();
        rst = 1'b0;
        tick();
        set_idle();
        idle_cycles(2, 1'b0);

        // Write, acknowledged on the third bus cycle
        run_txn(1'b0, 19'h00002, 2'b11, 16'hBEEF, 3, 0, 16'h0000, 0);
        check("dir_wr_run", 32'(last_run), 32'd3);
        check("dir_wr_data", 32'(last_rsp_data), 32'h0000);
        check("dir_wr_err", 32'(last_rsp_err), 32'd0);
        idle_cycles(1, 1'b0);

        // Read, acknowledged in the first bus cycle, response held off for 5 cycles
        run_txn(1'b1, 19'h00004, 2'b01, 16'h0000, 1, 5, 16'h12A5, 0);
        check("dir_rd_run", 32'(last_run), 32'd1);
        check("dir_rd_data", 32'(last_rsp_data), 32'h12A5);
        check("dir_rd_err", 32'(last_rsp_err), 32'd0);

        // Back-to-back commands with no idle gap
        run_txn(1'b0, 19'h7FFFF, 2'b10, 16'h5A5A, 2, 0, 16'h0000, 0);
        run_txn(1'b1, 19'h00010, 2'b11, 16'h0000, 1, 0, 16'hC3C3, 0);
        check("b2b_rd_data", 32'(last_rsp_data), 32'hC3C3);

        // Zero byte-enable is rejected without a bus cycle; stray acks afterwards do nothing
        runs_before = n_runs;
        run_txn(1'b1, 19'h00020, 2'b00, 16'h0000, 1, 0, 16'hFFFF, 0);
        check("rej_err", 32'(last_rsp_err), 32'd1);
        check("rej_data", 32'(last_rsp_data), 32'h0000);
        check("rej_no_bus", 32'(n_runs), 32'(runs_before));
        rsp_before = n_rsp;
        idle_cycles(4, 1'b1);
        check("stray_ack_no_rsp", 32'(n_rsp), 32'(rsp_before));

`ifdef EXT_BUS_TIMEOUT_EN
        run_txn(1'b1, 19'h00100, 2'b11, 16'h0000, 40, 1, 16'h1111, 0);
        check("tmo_run", 32'(last_run), 32'(TMO));
        check("tmo_err", 32'(last_rsp_err), 32'd1);
        check("tmo_data", 32'(last_rsp_data), 32'h0000);
        run_txn(1'b1, 19'h00104, 2'b11, 16'h0000, TMO, 0, 16'hA55A, 0);
        check("tmo_ack_run", 32'(last_run), 32'(TMO));
        check("tmo_ack_err", 32'(last_rsp_err), 32'd0);
        check("tmo_ack_data", 32'(last_rsp_data), 32'hA55A);
        idle_cycles(1, 1'b0);
`endif

        // Reset in the second bus cycle of a write
        rsp_before = n_rsp;
        run_txn(1'b0, 19'h00200, 2'b11, 16'h1234, 5, 0, 16'h0000, 2);
        idle_cycles(2, 1'b0);
        check("rst_no_rsp", 32'(n_rsp), 32'(rsp_before));

        // Randomized traffic; the middle block keeps rsp_ready permanently high
        for (int t = 0; t < 160; t++) begin
            logic [BW-1:0] be_r;
            int            d_r, s_r;
            perm_rdy = (t >= 60 && t < 90);
            be_r = ($urandom_range(0, 5) == 0) ? '0 : BW'($urandom_range(1, (1 << BW) - 1));
`ifdef EXT_BUS_TIMEOUT_EN
            d_r = $urandom_range(1, 12);
`else
            d_r = $urandom_range(1, 6);
`endif
            s_r = perm_rdy ? 0 : $urandom_range(0, 3);
            run_txn(1'($urandom), AW'($urandom), be_r, DW'($urandom), d_r, s_r, DW'($urandom), 0);
            idle_cycles($urandom_range(0, 2), 1'b0);
        end
        perm_rdy = 1'b0;
        idle_cycles(3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
